ingress_writer: RTL and testbench
=================================

INGRESS_WRITER -- requirements
Module: ingress_writer

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 4094, meaning the highest input-RAM address usable by a terminator word.
REQ-002 SHALL have parameter MAX_PKT_WORDS, default 1024, meaning the maximum number of non-terminator words per packet.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_data, input, 32 bits: packet word; bits [1:0] of the first word are the destination port.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 SHALL have port in_last, input, 1 bit: the current word is the final word of its packet.
REQ-008 SHALL have port in_ready, output, 1 bit: a word is accepted when in_valid and in_ready are both 1.
REQ-009 SHALL have port ram_wren, output, 1 bit: input-RAM write strobe.
REQ-010 SHALL have port ram_wr_add, output, 12 bits: input-RAM write address.
REQ-011 SHALL have port ram_wr_data, output, 32 bits: input-RAM write data.
REQ-012 SHALL have port input_ram_wr_add, output, 12 bits: committed fill pointer, i.e. one past the last committed terminator; consumed by the scheduler's rd_add < wr_add test.
REQ-013 SHALL have port pkt_count, output, 16 bits: number of committed packets.
REQ-014 SHALL have port drop_count, output, 16 bits: number of dropped packets.

Function
REQ-015 SHALL keep an internal write pointer wp and a commit pointer cp, both 12 bits; input_ram_wr_add SHALL always equal cp.
REQ-016 SHALL use a state machine with states IDLE, PAYLOAD, TERM and DROP.
REQ-017 SHALL drive in_ready to 1 in IDLE, PAYLOAD and DROP, and to 0 in TERM and while reset is high.
REQ-018 SHALL, for each accepted word that is stored, register ram_wren=1, ram_wr_add=wp and ram_wr_data=in_data on the next edge, and increment wp, giving a latency of 1 cycle.
REQ-019 SHALL drive ram_wren to 0 on every cycle without a write; ram_wr_add and ram_wr_data then hold their values.
REQ-020 SHALL treat a word as storable only if in_data!=0, wp<MAX_ADDR and the packet word count is below MAX_PKT_WORDS.
REQ-021 SHALL, in IDLE with an accepted storable word, store it and move to TERM if in_last=1, otherwise to PAYLOAD.
REQ-022 SHALL, in IDLE with an accepted unstorable word, increment drop_count and move to IDLE if in_last=1, otherwise to DROP.
REQ-023 SHALL, in PAYLOAD with an accepted storable word, store it and move to TERM if in_last=1, otherwise stay in PAYLOAD.
REQ-024 SHALL, in PAYLOAD with an accepted unstorable word (a zero word, buffer full or over-length), set wp to cp, increment drop_count, and move to IDLE if in_last=1, otherwise to DROP.
REQ-025 SHALL, in DROP, discard accepted words without writing and return to IDLE on the word with in_last=1.
REQ-026 SHALL, in TERM, write 32'h0 at wp, set wp and cp to wp+1, increment pkt_count and return to IDLE in one cycle; input_ram_wr_add SHALL update on that same edge as the terminator's ram_wren pulse.
REQ-027 SHALL never move cp past an uncommitted word, so a partial or dropped packet is never visible to the scheduler.
REQ-028 SHALL saturate pkt_count and drop_count at 16'hFFFF.
REQ-029 SHALL not wrap the buffer: once wp reaches MAX_ADDR, every new packet SHALL be dropped until reset.
REQ-030 SHALL ignore in_last and in_data when in_valid=0.

Reset
REQ-031 SHALL, while reset=1 on a clock edge, set state=IDLE, wp=0, cp=0, ram_wren=0, ram_wr_add=0, ram_wr_data=0, input_ram_wr_add=0, pkt_count=0, drop_count=0 and in_ready=0.
REQ-032 SHALL, on reset in mid-packet, discard the partial packet without counting a drop; in_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-033 SHALL cover a single packet 0x11,0x22,0x33 (last on 0x33) after reset: writes to addresses 0,1,2, then 0x0 at address 3; input_ram_wr_add goes 0->4; pkt_count=1.
REQ-034 SHALL cover a packet 0x5,0x0,0x7 (last on 0x7): no commit; wp rolls back to 0; drop_count=1; the next packet 0x9 (last) writes 0x9 at address 0 and 0x0 at address 1.
REQ-035 SHALL cover MAX_ADDR=5 with a 6-word packet: words are written to addresses 0..4 and the 6th word forces a drop; input_ram_wr_add stays 0; a following 1-word packet is also dropped.
REQ-036 SHALL cover back-to-back single-word packets 0xA and 0xB with in_valid held high: in_ready=0 for one cycle after each packet; addresses 0..3 get A,0,B,0; pkt_count=2.
REQ-037 SHALL cover reset asserted after 2 words of a packet: all outputs return to 0; drop_count=0; the next packet starts at address 0.
REQ-038 SHALL cover MAX_PKT_WORDS=2 with a 3-word packet: drop_count=1; input_ram_wr_add is unchanged.

Source files
------------

// File: rtl/ingress_writer.sv
// Packet ingress writer: stores accepted words into the input RAM, appends a zero
// terminator per packet and only then advances the commit pointer seen by the scheduler.
module ingress_writer #(
   parameter int unsigned MAX_ADDR      = 4094,
   parameter int unsigned MAX_PKT_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic        ram_wren,
   output logic [11:0] ram_wr_add,
   output logic [31:0] ram_wr_data,
   output logic [11:0] input_ram_wr_add,
   output logic [15:0] pkt_count,
   output logic [15:0] drop_count
);

   typedef enum logic [1:0] {IDLE, PAYLOAD, TERM, DROP} state_t;

   state_t      state_q, state_d;
   logic [11:0] wp_q, wp_d;
   logic [11:0] cp_q, cp_d;
   logic [15:0] words_q, words_d;
   logic        full_q, full_d;
   logic        ram_wren_q, ram_wren_d;
   logic [11:0] ram_wr_add_q, ram_wr_add_d;
   logic [31:0] ram_wr_data_q, ram_wr_data_d;
   logic [15:0] pkt_count_q, pkt_count_d;
   logic [15:0] drop_count_q, drop_count_d;

   logic        accept;
   logic        storable;
   logic [15:0] words_cur;
   logic [15:0] drop_inc;

   assign in_ready  = !reset && (state_q != TERM);
   assign accept    = in_valid && in_ready;
   assign words_cur = (state_q == IDLE) ? 16'd0 : words_q;
   // full_q keeps the buffer closed after a rollback lowers wp again: no wrap until reset
   assign storable  = (in_data != 32'd0) && !full_q &&
                      ({20'd0, wp_q} < MAX_ADDR) &&
                      ({16'd0, words_cur} < MAX_PKT_WORDS);
   assign drop_inc  = (drop_count_q == 16'hFFFF) ? drop_count_q : drop_count_q + 16'd1;

   always_comb begin
      state_d       = state_q;
      wp_d          = wp_q;
      cp_d          = cp_q;
      words_d       = words_q;
      ram_wren_d    = 1'b0;
      ram_wr_add_d  = ram_wr_add_q;
      ram_wr_data_d = ram_wr_data_q;
      pkt_count_d   = pkt_count_q;
      drop_count_d  = drop_count_q;
      case (state_q)
         IDLE, PAYLOAD: begin
            if (accept) begin
               if (storable) begin
                  ram_wren_d    = 1'b1;
                  ram_wr_add_d  = wp_q;
                  ram_wr_data_d = in_data;
                  wp_d          = wp_q + 12'd1;
                  words_d       = words_cur + 16'd1;
                  state_d       = in_last ? TERM : PAYLOAD;
               end else begin
                  wp_d         = cp_q;
                  drop_count_d = drop_inc;
                  state_d      = in_last ? IDLE : DROP;
               end
            end
         end
         TERM: begin
            ram_wren_d    = 1'b1;
            ram_wr_add_d  = wp_q;
            ram_wr_data_d = 32'd0;
            wp_d          = wp_q + 12'd1;
            cp_d          = wp_q + 12'd1;
            pkt_count_d   = (pkt_count_q == 16'hFFFF) ? pkt_count_q : pkt_count_q + 16'd1;
            state_d       = IDLE;
         end
         DROP: begin
            if (accept && in_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      full_d = full_q || ({20'd0, wp_d} >= MAX_ADDR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         wp_q          <= 12'd0;
         cp_q          <= 12'd0;
         words_q       <= 16'd0;
         full_q        <= 1'b0;
         ram_wren_q    <= 1'b0;
         ram_wr_add_q  <= 12'd0;
         ram_wr_data_q <= 32'd0;
         pkt_count_q   <= 16'd0;
         drop_count_q  <= 16'd0;
      end else begin
         state_q       <= state_d;
         wp_q          <= wp_d;
         cp_q          <= cp_d;
         words_q       <= words_d;
         full_q        <= full_d;
         ram_wren_q    <= ram_wren_d;
         ram_wr_add_q  <= ram_wr_add_d;
         ram_wr_data_q <= ram_wr_data_d;
         pkt_count_q   <= pkt_count_d;
         drop_count_q  <= drop_count_d;
      end
   end

   assign ram_wren         = ram_wren_q;
   assign ram_wr_add       = ram_wr_add_q;
   assign ram_wr_data      = ram_wr_data_q;
   assign input_ram_wr_add = cp_q;
   assign pkt_count        = pkt_count_q;
   assign drop_count       = drop_count_q;

endmodule

// File: tb/tb_ingress_writer.sv
// Directed bench for ingress_writer: three instances (default, MAX_ADDR=5, MAX_PKT_WORDS=2)
// share the stimulus; only the selected one sees in_valid.
module tb_ingress_writer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_data = 32'd0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   int          sel = 0;

   logic        rdy [3];
   logic        wren [3];
   logic [11:0] wadd [3];
   logic [31:0] wdat [3];
   logic [11:0] cpa [3];
   logic [15:0] pkts [3];
   logic [15:0] drops [3];

   logic        cur_ready, cur_wren;
   logic [11:0] cur_wadd, cur_cp;
   logic [31:0] cur_wdat;
   logic [15:0] cur_pkts, cur_drops;

   int errors = 0;
   int checks = 0;
   logic [11:0] la[$];
   logic [31:0] ld[$];

   always #5 clk = ~clk;

   ingress_writer u_def (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid && sel == 0),
      .in_last(in_last), .in_ready(rdy[0]), .ram_wren(wren[0]), .ram_wr_add(wadd[0]),
      .ram_wr_data(wdat[0]), .input_ram_wr_add(cpa[0]), .pkt_count(pkts[0]),
      .drop_count(drops[0]));

   ingress_writer #(.MAX_ADDR(5)) u_small (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid && sel == 1),
      .in_last(in_last), .in_ready(rdy[1]), .ram_wren(wren[1]), .ram_wr_add(wadd[1]),
      .ram_wr_data(wdat[1]), .input_ram_wr_add(cpa[1]), .pkt_count(pkts[1]),
      .drop_count(drops[1]));

   ingress_writer #(.MAX_PKT_WORDS(2)) u_short (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid && sel == 2),
      .in_last(in_last), .in_ready(rdy[2]), .ram_wren(wren[2]), .ram_wr_add(wadd[2]),
      .ram_wr_data(wdat[2]), .input_ram_wr_add(cpa[2]), .pkt_count(pkts[2]),
      .drop_count(drops[2]));

   assign cur_ready = rdy[sel];
   assign cur_wren  = wren[sel];
   assign cur_wadd  = wadd[sel];
   assign cur_wdat  = wdat[sel];
   assign cur_cp    = cpa[sel];
   assign cur_pkts  = pkts[sel];
   assign cur_drops = drops[sel];

   always @(negedge clk) begin
      if (cur_wren) begin
         la.push_back(cur_wadd);
         ld.push_back(cur_wdat);
         $display("write: dut=%0d addr=%0d data=%08h", sel, cur_wadd, cur_wdat);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_log(input int idx, input logic [11:0] a, input logic [31:0] d);
      logic [11:0] oa;
      logic [31:0] od;
      oa = (idx < la.size()) ? la[idx] : 12'hxxx;
      od = (idx < ld.size()) ? ld[idx] : 32'hxxxxxxxx;
      chk($sformatf("wr%0d_addr", idx), {20'd0, oa}, {20'd0, a});
      chk($sformatf("wr%0d_data", idx), od, d);
   endtask

   task automatic send(input logic [31:0] d, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!cur_ready && n <= 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n > 20) begin
         checks++;
         errors++;
         $error("FAIL send_timeout: observed=not_ready expected=ready data=%0h", d);
      end
      @(posedge clk); #1;
      $display("accepted: dut=%0d data=%08h last=%0b", sel, d, l);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 32'd0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      in_last  = 1'b0;
      reset    = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      la.delete();
      ld.delete();
      #1;
   endtask

   initial begin
      // Reset state, in_ready low during reset and high right after it
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wren", {31'd0, cur_wren}, 32'd0);
      chk("rst_wadd", {20'd0, cur_wadd}, 32'd0);
      chk("rst_wdat", cur_wdat, 32'd0);
      chk("rst_cp", {20'd0, cur_cp}, 32'd0);
      chk("rst_pkts", {16'd0, cur_pkts}, 32'd0);
      chk("rst_drops", {16'd0, cur_drops}, 32'd0);
      chk("rst_ready", {31'd0, cur_ready}, 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", {31'd0, cur_ready}, 32'd1);

      // Single packet 11,22,33
      sel = 0;
      do_reset();
      send(32'h11, 1'b0);
      send(32'h22, 1'b0);
      send(32'h33, 1'b1);
      chk("p1_term_ready", {31'd0, cur_ready}, 32'd0);
      chk("p1_cp_before", {20'd0, cur_cp}, 32'd0);
      idle(1);
      chk("p1_term_wren", {31'd0, cur_wren}, 32'd1);
      chk("p1_term_addr", {20'd0, cur_wadd}, 32'd3);
      chk("p1_term_data", cur_wdat, 32'd0);
      chk("p1_cp_after", {20'd0, cur_cp}, 32'd4);
      idle(2);
      chk("p1_wren_idle", {31'd0, cur_wren}, 32'd0);
      chk("p1_wadd_hold", {20'd0, cur_wadd}, 32'd3);
      chk("p1_pkts", {16'd0, cur_pkts}, 32'd1);
      chk("p1_nwr", la.size(), 32'd4);
      chk_log(0, 12'd0, 32'h11);
      chk_log(1, 12'd1, 32'h22);
      chk_log(2, 12'd2, 32'h33);
      chk_log(3, 12'd3, 32'h0);

      // Zero word inside a packet: rollback and drop
      do_reset();
      send(32'h5, 1'b0);
      send(32'h0, 1'b0);
      send(32'h7, 1'b1);
      idle(2);
      chk("p2_drops", {16'd0, cur_drops}, 32'd1);
      chk("p2_cp", {20'd0, cur_cp}, 32'd0);
      send(32'h9, 1'b1);
      idle(3);
      chk("p2_nwr", la.size(), 32'd3);
      chk_log(0, 12'd0, 32'h5);
      chk_log(1, 12'd0, 32'h9);
      chk_log(2, 12'd1, 32'h0);
      chk("p2_pkts", {16'd0, cur_pkts}, 32'd1);
      chk("p2_cp_after", {20'd0, cur_cp}, 32'd2);

      // MAX_ADDR=5: buffer fills, later packets dropped
      sel = 1;
      do_reset();
      for (int i = 1; i <= 6; i++) send(32'(i), (i == 6));
      idle(1);
      chk("p3_drops1", {16'd0, cur_drops}, 32'd1);
      send(32'h77, 1'b1);
      idle(2);
      chk("p3_drops2", {16'd0, cur_drops}, 32'd2);
      chk("p3_cp", {20'd0, cur_cp}, 32'd0);
      chk("p3_pkts", {16'd0, cur_pkts}, 32'd0);
      chk("p3_nwr", la.size(), 32'd5);
      for (int i = 0; i < 5; i++) chk_log(i, 12'(i), 32'(i + 1));

      // Back-to-back single-word packets with in_valid held high
      sel = 0;
      do_reset();
      send(32'hA, 1'b1);
      chk("p4_ready_a", {31'd0, cur_ready}, 32'd0);
      send(32'hB, 1'b1);
      chk("p4_ready_b", {31'd0, cur_ready}, 32'd0);
      idle(3);
      chk("p4_pkts", {16'd0, cur_pkts}, 32'd2);
      chk("p4_nwr", la.size(), 32'd4);
      chk_log(0, 12'd0, 32'hA);
      chk_log(1, 12'd1, 32'h0);
      chk_log(2, 12'd2, 32'hB);
      chk_log(3, 12'd3, 32'h0);

      // Reset in mid-packet
      do_reset();
      send(32'h21, 1'b0);
      send(32'h22, 1'b0);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk); #1;
      chk("p5_wren", {31'd0, cur_wren}, 32'd0);
      chk("p5_wadd", {20'd0, cur_wadd}, 32'd0);
      chk("p5_wdat", cur_wdat, 32'd0);
      chk("p5_cp", {20'd0, cur_cp}, 32'd0);
      chk("p5_drops", {16'd0, cur_drops}, 32'd0);
      chk("p5_ready_rst", {31'd0, cur_ready}, 32'd0);
      reset = 1'b0;
      #1;
      chk("p5_ready_after", {31'd0, cur_ready}, 32'd1);
      la.delete();
      ld.delete();
      send(32'h31, 1'b1);
      idle(3);
      chk("p5_nwr", la.size(), 32'd2);
      chk_log(0, 12'd0, 32'h31);
      chk_log(1, 12'd1, 32'h0);
      chk("p5_pkts", {16'd0, cur_pkts}, 32'd1);
      chk("p5_drops_after", {16'd0, cur_drops}, 32'd0);

      // MAX_PKT_WORDS=2 with a 3-word packet
      sel = 2;
      do_reset();
      send(32'h1, 1'b0);
      send(32'h2, 1'b0);
      send(32'h3, 1'b1);
      idle(2);
      chk("p6_drops", {16'd0, cur_drops}, 32'd1);
      chk("p6_cp", {20'd0, cur_cp}, 32'd0);
      chk("p6_pkts", {16'd0, cur_pkts}, 32'd0);
      chk("p6_nwr", la.size(), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
